// File: rtl/midi_cmd_feeder_pkg.sv
// Shared constants, state encoding and command decode helpers for the MIDI command feeder.
// The command layout is fixed: [15] START/STOP, [14:8] note, [7:0] payload.
package midi_cmd_feeder_pkg;

  localparam int CMD_W         = 16;
  localparam int CMD_START_BIT = 15;
  localparam int NOTE_MSB      = 14;
  localparam int NOTE_LSB      = 8;
  localparam logic [NOTE_MSB-NOTE_LSB:0] STOP_ALL_NOTE = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } feeder_state_e;

  // Note 0 is reserved as "off", so a START on it is meaningless; an all-zero word is
  // indistinguishable from the idle bus.
  function automatic logic is_valid_cmd(input logic [CMD_W-1:0] cmd);
    logic start_cmd;
    logic note_zero;
    start_cmd = cmd[CMD_START_BIT];
    note_zero = (cmd[NOTE_MSB:NOTE_LSB] == '0);
    return (cmd != '0) && !(start_cmd && note_zero);
  endfunction

  function automatic logic is_stop_all(input logic [CMD_W-1:0] cmd);
    return !cmd[CMD_START_BIT] && (cmd[NOTE_MSB:NOTE_LSB] == STOP_ALL_NOTE);
  endfunction

endpackage

// File: rtl/midi_cmd_feeder_if.sv
// Host-side write port and bank-manager-side command output of the MIDI command feeder.
// The master modport is the host/bridge view, the slave modport is the feeder itself.
interface midi_cmd_feeder_if
  import midi_cmd_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) ();

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             i_wr;
  logic [CMD_W-1:0] i_wdata;
  logic             i_clr_ovf;
  logic             o_full;
  logic [LVL_W-1:0] o_level;
  logic             o_overflow;
  logic [CMD_W-1:0] o_data;

  modport master (
    output i_wr,
    output i_wdata,
    output i_clr_ovf,
    input  o_full,
    input  o_level,
    input  o_overflow,
    input  o_data
  );

  modport slave (
    input  i_wr,
    input  i_wdata,
    input  i_clr_ovf,
    output o_full,
    output o_level,
    output o_overflow,
    output o_data
  );

endinterface

// File: rtl/midi_cmd_feeder_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through head and a single-cycle flush.
// Pointers carry one extra bit so full and empty are distinguishable after wrap-around.
module cmd_fifo
  import midi_cmd_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A flush rebases both pointers to zero; a push in the same cycle lands in slot 0
  // and becomes the only entry.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_d[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/midi_cmd_feeder.sv
// Buffers host note commands and presents each one for a single clock, followed by GAP zero cycles.
// Build option STOP_ALL_FLUSH_EN: an accepted STOP_ALL discards every queued, not-yet-issued command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight; pops the FIFO head as soon as one exists
// ST_ISSUE | o_data carries the command for this one cycle
// ST_GAP   | o_data held at zero while cnt_q counts down to zero
module midi_cmd_feeder
  import midi_cmd_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  midi_cmd_feeder_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  logic             pop;
  logic             push;
  logic             flush;
  logic             cmd_valid;
  logic             wr_drop;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.i_wdata),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // The last gap cycle hands straight over to the next issue, so queued commands
  // leave every GAP+1 cycles instead of paying an extra IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
        cnt_d   = CNT_W'(GAP - 1);
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pop    = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == '0)));
    data_d = pop ? fifo_head : '0;
  end

  // A pop in the same cycle frees a slot, so a write against a full FIFO still lands.
  always_comb begin
    cmd_valid = is_valid_cmd(bus.i_wdata);
    push      = bus.i_wr && cmd_valid && (!fifo_full || pop);
    wr_drop   = bus.i_wr && !push;
    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (bus.i_clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
`ifdef STOP_ALL_FLUSH_EN
    flush = push && is_stop_all(bus.i_wdata);
`else
    flush = 1'b0;
`endif
  end

  assign bus.o_data     = data_q;
  assign bus.o_full     = fifo_full;
  assign bus.o_level    = fifo_level;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_midi_cmd_feeder.sv
// Directed bench for midi_cmd_feeder: a per-cycle vector table plus hand sequences for
// reset during issue and the STOP_ALL case (expectations follow STOP_ALL_FLUSH_EN).
module tb_midi_cmd_feeder;

  typedef struct {
    logic        wr;
    logic [15:0] wdata;
    logic        clr;
    logic [15:0] exp_data;
    logic [3:0]  exp_level;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  vec_t        vecs[$];
  logic [15:0] issued[$];
  logic [15:0] exp_issued[$];
  int          exp_lvl;

  midi_cmd_feeder_if #(.DEPTH(8)) bus ();

  midi_cmd_feeder #(
    .DEPTH (8),
    .GAP   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [15:0] wdata, input logic clr,
                     input logic [15:0] d, input logic [3:0] l, input logic f, input logic o);
    vec_t v;
    v.wr = wr; v.wdata = wdata; v.clr = clr;
    v.exp_data = d; v.exp_level = l; v.exp_full = f; v.exp_ovf = o;
    vecs.push_back(v);
  endtask

  // Drive at a negedge, let one posedge sample it, observe at the following negedge.
  task automatic step(input logic wr, input logic [15:0] wdata, input logic clr);
    bus.i_wr      = wr;
    bus.i_wdata   = wdata;
    bus.i_clr_ovf = clr;
    @(posedge clk);
    @(negedge clk);
    if (bus.o_data != 16'h0) issued.push_back(bus.o_data);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n         = 1'b0;
    bus.i_wr      = 1'b0;
    bus.i_wdata   = 16'h0;
    bus.i_clr_ovf = 1'b0;

    // single write
    add(1, 16'h8540, 0, 16'h0000, 1, 0, 0);
    add(0, 16'h0000, 0, 16'h8540, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // three back-to-back writes
    add(1, 16'h8540, 0, 16'h0000, 1, 0, 0);
    add(1, 16'h8740, 0, 16'h8540, 1, 0, 0);
    add(1, 16'h0540, 0, 16'h0000, 2, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 2, 0, 0);
    add(0, 16'h0000, 0, 16'h8740, 1, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    add(0, 16'h0000, 0, 16'h0540, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // invalid commands, sticky overflow, clear, set-wins
    add(1, 16'h8000, 0, 16'h0000, 0, 0, 1);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    add(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    add(1, 16'h8000, 1, 16'h0000, 0, 0, 1);
    add(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add(1, 16'h00FF, 0, 16'h0000, 1, 0, 0);
    add(0, 16'h0000, 0, 16'h00FF, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // fill while issuing every 3 cycles
    add(1, 16'h8101, 0, 16'h0000, 1, 0, 0);
    add(1, 16'h8102, 0, 16'h8101, 1, 0, 0);
    add(1, 16'h8103, 0, 16'h0000, 2, 0, 0);
    add(1, 16'h8104, 0, 16'h0000, 3, 0, 0);
    add(1, 16'h8105, 0, 16'h8102, 3, 0, 0);
    add(1, 16'h8106, 0, 16'h0000, 4, 0, 0);
    add(1, 16'h8107, 0, 16'h0000, 5, 0, 0);
    add(1, 16'h8108, 0, 16'h8103, 5, 0, 0);
    add(1, 16'h8109, 0, 16'h0000, 6, 0, 0);
    add(1, 16'h810A, 0, 16'h0000, 7, 0, 0);
    add(1, 16'h810B, 0, 16'h8104, 7, 0, 0);
    add(1, 16'h810C, 0, 16'h0000, 8, 1, 0);
    add(1, 16'h810D, 0, 16'h0000, 8, 1, 1);
    add(1, 16'h810E, 1, 16'h8105, 8, 1, 0);

    @(negedge clk);
    @(negedge clk);
    check("reset o_data", 32'(bus.o_data), 32'h0);
    check("reset o_level", 32'(bus.o_level), 32'h0);
    check("reset o_full", 32'(bus.o_full), 32'h0);
    check("reset o_overflow", 32'(bus.o_overflow), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].wdata, vecs[i].clr);
      check($sformatf("vec%0d o_data", i), 32'(bus.o_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d o_level", i), 32'(bus.o_level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d o_full", i), 32'(bus.o_full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d o_overflow", i), 32'(bus.o_overflow), 32'(vecs[i].exp_ovf));
    end
    bus.i_wr      = 1'b0;
    bus.i_wdata   = 16'h0;
    bus.i_clr_ovf = 1'b0;

    // reset while 16'h8105 is on o_data with a full queue behind it
    rst_n = 1'b0;
    #1;
    check("rst mid-issue o_data", 32'(bus.o_data), 32'h0);
    check("rst mid-issue o_level", 32'(bus.o_level), 32'h0);
    check("rst mid-issue o_full", 32'(bus.o_full), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h8C21, 0);
    check("post-rst write o_level", 32'(bus.o_level), 32'h1);
    check("post-rst write o_data early", 32'(bus.o_data), 32'h0);
    step(0, 16'h0, 0);
    check("post-rst issue o_data", 32'(bus.o_data), 32'h8C21);
    step(0, 16'h0, 0);
    check("post-rst gap o_data", 32'(bus.o_data), 32'h0);
    step(0, 16'h0, 0);
    step(0, 16'h0, 0);

    // STOP_ALL behind four queued STARTs
`ifdef STOP_ALL_FLUSH_EN
    exp_issued = '{16'h8A01, 16'h8A02, 16'h7F00};
    exp_lvl    = 1;
`else
    exp_issued = '{16'h8A01, 16'h8A02, 16'h8A03, 16'h8A04, 16'h7F00};
    exp_lvl    = 3;
`endif
    issued.delete();
    step(1, 16'h8A01, 0);
    step(1, 16'h8A02, 0);
    step(1, 16'h8A03, 0);
    step(1, 16'h8A04, 0);
    step(0, 16'h0, 0);
    step(1, 16'h7F00, 0);
    check("stop_all o_level", 32'(bus.o_level), 32'(exp_lvl));
    for (int i = 0; i < 12; i++) step(0, 16'h0, 0);
    check("stop_all issue count", 32'(issued.size()), 32'(exp_issued.size()));
    for (int i = 0; i < exp_issued.size() && i < issued.size(); i++) begin
      check($sformatf("stop_all issue%0d", i), 32'(issued[i]), 32'(exp_issued[i]));
    end
    check("stop_all drained o_level", 32'(bus.o_level), 32'h0);
    check("stop_all o_overflow", 32'(bus.o_overflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
